// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the instruction-memory port, keeps a
// 2-entry prefetch buffer feeding decode, and lets a program-load port
// take over the memory for writes.
module ifetch_ctrl #(
    parameter int          ADDR_W   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0033
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [31:0]       ins,
    output logic [31:0]       ins_pc,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, RUN, LOAD} state_t;

    state_t            state;
    logic [31:0]       fetch_pc;
    logic              rd_pending;
    logic [31:0]       rd_pc;
    logic [ADDR_W-1:0] addr_hold;

    // Buffer slot 0 is the head and drives decode directly; slot 1 is the tail.
    logic              v0, v1;
    logic [31:0]       d0, p0, d1, p1;

    logic [1:0]        count;
    logic [2:0]        occupancy;
    logic              load_exit, redirect_flush, flush;
    logic              pop, push, issue;
    logic [31:0]       redirect_pc_al, issue_pc, fetch_pc_n;
    logic              n_v0, n_v1;
    logic [31:0]       n_d0, n_p0, n_d1, n_p1;
    logic              unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];
    assign count          = {1'b0, v0} + {1'b0, v1};
    assign ins_valid      = v0;
    assign ins            = d0;
    assign ins_pc         = p0;

    // Control decode: flush/pop/push/issue decisions and memory port muxing.
    always_comb begin
        load_exit      = (state == LOAD) && !ld_req;
        redirect_flush = redirect_valid && (state != LOAD);
        flush          = redirect_flush || load_exit;
        pop            = v0 && ins_ready && !flush;
        push           = rd_pending && (state != LOAD) && !flush;
        redirect_pc_al = {redirect_pc[31:2], 2'b00};
        occupancy      = 3'd0;
        if (!flush) begin
            occupancy = {1'b0, count} - {2'b00, pop} + {2'b00, rd_pending};
        end
        issue    = (state == RUN) && en && (occupancy < 3'd2);
        issue_pc = redirect_flush ? redirect_pc_al : fetch_pc;

        fetch_pc_n = redirect_valid ? redirect_pc_al : fetch_pc;
        if (issue) begin
            fetch_pc_n = issue_pc + 32'd4;
        end

        ld_gnt    = (state == LOAD) && ld_req;
        mem_we    = ld_gnt;
        mem_wdata = ld_gnt ? ld_wdata : 32'h0;
        if (ld_gnt) begin
            mem_addr = ld_addr;
        end else if (issue) begin
            mem_addr = issue_pc[ADDR_W+1:2];
        end else begin
            mem_addr = addr_hold;
        end
    end

    // Next contents of the prefetch buffer: pop shifts tail to head, push fills the first free slot.
    always_comb begin
        n_v0 = v0;
        n_d0 = d0;
        n_p0 = p0;
        n_v1 = v1;
        n_d1 = d1;
        n_p1 = p1;
        if (pop) begin
            n_v0 = v1;
            n_d0 = d1;
            n_p0 = p1;
            n_v1 = 1'b0;
        end
        if (push) begin
            if (!n_v0) begin
                n_v0 = 1'b1;
                n_d0 = mem_rdata;
                n_p0 = rd_pc;
            end else begin
                n_v1 = 1'b1;
                n_d1 = mem_rdata;
                n_p1 = rd_pc;
            end
        end
        if (flush) begin
            n_v0 = 1'b0;
            n_v1 = 1'b0;
        end
        if (!n_v0) begin
            n_d0 = NOP;
            n_p0 = 32'h0;
        end
    end

    // Sequencer state machine: idle / fetching / program-load ownership of the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_req)  state <= LOAD;
                    else if (en) state <= RUN;
                end
                RUN: begin
                    if (ld_req)   state <= LOAD;
                    else if (!en) state <= IDLE;
                end
                LOAD: begin
                    if (!ld_req) state <= en ? RUN : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Fetch PC, outstanding-read tracking and the held memory address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            rd_pending <= 1'b0;
            rd_pc      <= 32'h0;
            addr_hold  <= '0;
        end else begin
            fetch_pc   <= fetch_pc_n;
            rd_pending <= issue;
            if (issue) rd_pc <= issue_pc;
            addr_hold  <= mem_addr;
        end
    end

    // Prefetch buffer registers; an empty head shows NOP at PC 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            d0 <= NOP;
            p0 <= 32'h0;
            v1 <= 1'b0;
            d1 <= 32'h0;
            p1 <= 32'h0;
        end else begin
            v0 <= n_v0;
            d0 <= n_d0;
            p0 <= n_p0;
            v1 <= n_v1;
            d1 <= n_d1;
            p1 <= n_p1;
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed testbench for ifetch_ctrl with a behavioural 16-word instruction memory.
module tb_ifetch_ctrl;
    localparam int          ADDR_W = 4;
    localparam logic [31:0] NOP    = 32'h0000_0033;

    logic              clk, rst_n, en, redirect_valid, ins_valid, ins_ready;
    logic [31:0]       redirect_pc, ins, ins_pc, ld_wdata, mem_wdata, mem_rdata;
    logic              ld_req, ld_gnt, mem_we;
    logic [ADDR_W-1:0] ld_addr, mem_addr;

    int   checks = 0;
    int   errors = 0;
    int   overflow_errs = 0;
    logic init_mem = 1'b0;
    logic [31:0] mem [16];

    ifetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(32'h0), .NOP(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins), .ins_pc(ins_pc),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] aword(input int i);
        return 32'hA0A0_0000 + 32'(i);
    endfunction

    function automatic logic [31:0] dword(input int i);
        return 32'hD00D_0000 + 32'(i);
    endfunction

    // Synchronous read-first memory with a 1-cycle read latency.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= aword(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    // Buffered entries plus the outstanding read must never exceed two.
    always @(negedge clk) begin
        if (rst_n && (({1'b0, dut.count} + {2'b00, dut.rd_pending}) > 3'd2)) begin
            overflow_errs++;
            $display("FAIL fifo_overflow count=%0d pending=%0b", dut.count, dut.rd_pending);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic en_v, input logic rdy_v);
        rst_n = 1'b0; en = en_v; ins_ready = rdy_v;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        ld_req = 1'b0; ld_addr = '0; ld_wdata = 32'h0;
        init_mem = 1'b1;
        tick;
        tick;
        init_mem = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [101:0] obs, want;
        do_reset(1'b1, 1'b1);
        rst_n = 1'b0;
        #2;
        obs  = {ins_valid, ins, ins_pc, ld_gnt, mem_we, mem_addr, mem_wdata};
        want = {1'b0, NOP, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0};
        checks++;
        if (obs !== want) begin errors++; $display("FAIL reset_values got %h want %h", obs, want); end
        tick;
        tick;
        checks++;
        if ({ins_valid, mem_addr} !== 5'h0) begin
            errors++; $display("FAIL reset_hold got %0b/%h want 0/0", ins_valid, mem_addr);
        end
    endtask

    task automatic test_stream;
        logic [64:0] obs, want;
        do_reset(1'b1, 1'b1);
        for (int c = 1; c <= 2; c++) begin
            tick;
            checks++;
            if (ins_valid !== 1'b0) begin errors++; $display("FAIL stream_latency_e%0d got %0b want 0", c, ins_valid); end
        end
        for (int k = 0; k < 4; k++) begin
            tick;
            obs = {ins_valid, ins, ins_pc}; want = {1'b1, aword(k), 32'(k * 4)};
            checks++;
            if (obs !== want) begin errors++; $display("FAIL stream_word%0d got %h want %h", k, obs, want); end
        end
    endtask

    task automatic test_backpressure;
        logic [68:0] obs, want;
        logic [64:0] o2, w2;
        do_reset(1'b1, 1'b0);
        tick; tick; tick;
        for (int c = 0; c < 5; c++) begin
            obs = {ins_valid, ins, ins_pc, mem_addr}; want = {1'b1, aword(0), 32'h0, 4'd1};
            checks++;
            if (obs !== want) begin errors++; $display("FAIL stall_hold%0d got %h want %h", c, obs, want); end
            if (c < 4) tick;
        end
        ins_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick;
            o2 = {ins_valid, ins, ins_pc}; w2 = {1'b1, aword(k), 32'(k * 4)};
            checks++;
            if (o2 !== w2) begin errors++; $display("FAIL stall_drain%0d got %h want %h", k, o2, w2); end
        end
    endtask

    task automatic test_redirect_full;
        logic [64:0] obs, want;
        do_reset(1'b1, 1'b0);
        tick; tick; tick; tick; tick;
        redirect_valid = 1'b1; redirect_pc = 32'h22; ins_ready = 1'b1;
        #1;
        checks++;
        if (mem_addr !== 4'd8) begin errors++; $display("FAIL redir_issue_addr got %h want 8", mem_addr); end
        tick;
        redirect_valid = 1'b0;
        checks++;
        if (ins_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %0b want 0", ins_valid); end
        for (int k = 0; k < 2; k++) begin
            tick;
            obs = {ins_valid, ins, ins_pc}; want = {1'b1, aword(8 + k), 32'h20 + 32'(k * 4)};
            checks++;
            if (obs !== want) begin errors++; $display("FAIL redir_full_word%0d got %h want %h", k, obs, want); end
        end
    endtask

    task automatic test_redirect_squash;
        logic [64:0] obs, want;
        do_reset(1'b1, 1'b1);
        tick; tick; tick;
        redirect_valid = 1'b1; redirect_pc = 32'h30;
        tick;
        redirect_valid = 1'b0;
        checks++;
        if (ins_valid !== 1'b0) begin errors++; $display("FAIL squash_gap got %0b want 0", ins_valid); end
        for (int k = 0; k < 2; k++) begin
            tick;
            obs = {ins_valid, ins, ins_pc}; want = {1'b1, aword(12 + k), 32'h30 + 32'(k * 4)};
            checks++;
            if (obs !== want) begin errors++; $display("FAIL squash_word%0d got %h want %h", k, obs, want); end
        end
    endtask

    task automatic test_load;
        logic [37:0] obs, want;
        logic [64:0] o2, w2;
        do_reset(1'b1, 1'b1);
        tick; tick; tick; tick;
        ld_req = 1'b1; ld_addr = 4'd0; ld_wdata = dword(0);
        #1;
        checks++;
        if ({ld_gnt, mem_we} !== 2'b00) begin errors++; $display("FAIL load_wait got %b want 00", {ld_gnt, mem_we}); end
        tick;
        for (int i = 0; i < 3; i++) begin
            ld_addr = 4'(i); ld_wdata = dword(i);
            #1;
            obs = {ld_gnt, mem_we, mem_addr, mem_wdata}; want = {2'b11, 4'(i), dword(i)};
            checks++;
            if (obs !== want) begin errors++; $display("FAIL load_grant%0d got %h want %h", i, obs, want); end
            tick;
        end
        ld_req = 1'b0;
        #1;
        checks++;
        if ({ld_gnt, mem_we} !== 2'b00) begin errors++; $display("FAIL load_release got %b want 00", {ld_gnt, mem_we}); end
        tick;
        checks++;
        if (ins_valid !== 1'b0) begin errors++; $display("FAIL load_flush got %0b want 0", ins_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick;
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            o2 = {ins_valid, ins, ins_pc}; w2 = {1'b1, dword(i), 32'(i * 4)};
            checks++;
            if (o2 !== w2) begin errors++; $display("FAIL load_fetch%0d got %h want %h", i, o2, w2); end
        end
    endtask

    task automatic test_wrap;
        logic [64:0] obs, want;
        do_reset(1'b1, 1'b1);
        tick;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        #1;
        checks++;
        if (mem_addr !== 4'hE) begin errors++; $display("FAIL wrap_addr_e got %h want e", mem_addr); end
        tick;
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (mem_addr !== 4'hF) begin errors++; $display("FAIL wrap_addr_f got %h want f", mem_addr); end
        tick;
        checks++;
        if (mem_addr !== 4'h0) begin errors++; $display("FAIL wrap_addr_0 got %h want 0", mem_addr); end
        for (int k = 0; k < 3; k++) begin
            obs = {ins_valid, ins, ins_pc};
            want = {1'b1, aword((14 + k) % 16), 32'hFFFF_FFF8 + 32'(k * 4)};
            checks++;
            if (obs !== want) begin errors++; $display("FAIL wrap_word%0d got %h want %h", k, obs, want); end
            tick;
        end
    endtask

    task automatic test_enable_stop;
        logic [64:0] obs, want;
        do_reset(1'b1, 1'b0);
        tick; tick;
        en = 1'b0;
        tick;
        obs = {ins_valid, ins, ins_pc}; want = {1'b1, aword(0), 32'h0};
        checks++;
        if (obs !== want) begin errors++; $display("FAIL en_inflight got %h want %h", obs, want); end
        ins_ready = 1'b1;
        tick;
        checks++;
        if ({ins_valid, mem_addr} !== 5'h0) begin
            errors++; $display("FAIL en_drain got %0b/%h want 0/0", ins_valid, mem_addr);
        end
    endtask

    task automatic test_async_reset;
        logic [68:0] obs, want;
        logic [64:0] o2, w2;
        do_reset(1'b1, 1'b1);
        tick; tick; tick; tick;
        rst_n = 1'b0;
        #1;
        obs = {ins_valid, ins, ins_pc, mem_addr}; want = {1'b0, NOP, 32'h0, 4'h0};
        checks++;
        if (obs !== want) begin errors++; $display("FAIL async_reset got %h want %h", obs, want); end
        #2;
        rst_n = 1'b1;
        tick; tick;
        checks++;
        if (ins_valid !== 1'b0) begin errors++; $display("FAIL restart_latency got %0b want 0", ins_valid); end
        for (int k = 0; k < 2; k++) begin
            tick;
            o2 = {ins_valid, ins, ins_pc}; w2 = {1'b1, aword(k), 32'(k * 4)};
            checks++;
            if (o2 !== w2) begin errors++; $display("FAIL restart_word%0d got %h want %h", k, o2, w2); end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; ins_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        ld_req = 1'b0; ld_addr = '0; ld_wdata = 32'h0;
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect_full;
        test_redirect_squash;
        test_load;
        test_wrap;
        test_enable_stop;
        test_async_reset;
        checks++;
        if (overflow_errs !== 0) begin
            errors++; $display("FAIL fifo_overflow_total got %0d want 0", overflow_errs);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
